// File: rtl/three_phase_dds.sv
// three_phase_dds: burst three-channel sine generator with per-channel phase offsets
module three_phase_dds #(
  parameter int DATA_WIDTH = 14,
  parameter int FFT_DEPTH  = 11,
  parameter int LUT_ADDR   = 10,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ACC_WIDTH-1:0]  freq_word,
  input  logic [15:0]           phase1,
  input  logic [15:0]           phase2,
  input  logic [15:0]           phase3,
  input  logic [15:0]           div,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] data2,
  output logic [DATA_WIDTH-1:0] data3
);
  localparam int PW = LUT_ADDR + 2;
  localparam int N = 1 << LUT_ADDR;
  localparam logic [DATA_WIDTH-2:0] AMP = '1;
  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  // Table entry i = round(AMP * sin(pi*i/2^(LUT_ADDR+1))), built in 2^-60 fixed point so it is exact after rounding
  function automatic logic [DATA_WIDTH-2:0] sin_q(input int i);
    logic [127:0] x, x2, t, s;
    x = (128'h3243F6A8885A308D * 128'(i)) >> (LUT_ADDR + 1);
    x2 = (x * x) >> 60;
    t = x;
    s = x;
    for (int n = 1; n <= 12; n++) begin
      t = ((t * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
      s = (n % 2 == 1) ? s - t : s + t;
    end
    return (DATA_WIDTH-1)'((128'(AMP) * s + (128'd1 << 59)) >> 60);
  endfunction
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t                          state_q;
  logic                            busy_q, done_q, vld1_q, valid_q, tick, cnt_wrap;
  logic [ACC_WIDTH-1:0]            acc_q, freq_q;
  logic [15:0]                     div_q, cnt_q;
  logic [FFT_DEPTH-1:0]            smp_q;
  logic [2:0][15:0]                ph_q;
  logic [2:0][PW-1:0]              p_q, p_d;
  logic [2:0][DATA_WIDTH-1:0]      data_q, data_d;
  logic [DATA_WIDTH-2:0]           lut [N];
  for (genvar i = 0; i < N; i++) begin : g_lut
    localparam logic [DATA_WIDTH-2:0] V = sin_q(i);
    assign lut[i] = V;
  end
  assign tick = state_q == RUN && cnt_q == '0;
  assign cnt_wrap = cnt_q == div_q - 16'd1;
  // Odd quadrants mirror the index; the peak (index 2^LUT_ADDR) lies outside the table and is forced
  for (genvar k = 0; k < 3; k++) begin : g_ch
    logic [ACC_WIDTH-1:0]  sum;
    logic [1:0]            quad;
    logic [LUT_ADDR-1:0]   a, idx;
    logic [DATA_WIDTH-2:0] mag;
    assign sum = acc_q + (ACC_WIDTH'(ph_q[k]) << (ACC_WIDTH - 16));
    assign p_d[k] = sum[ACC_WIDTH-1 -: PW];
    assign quad = p_q[k][PW-1 -: 2];
    assign a = p_q[k][LUT_ADDR-1:0];
    assign idx = quad[0] ? -a : a;
    assign mag = (quad[0] && a == '0) ? AMP : lut[idx];
    assign data_d[k] = quad[1] ? MID - DATA_WIDTH'(mag) : MID + DATA_WIDTH'(mag);
  end
  // Burst control: latch settings on start, tick every div cycles, one flush cycle before done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      freq_q  <= '0;
      cnt_q   <= '0;
      smp_q   <= '0;
      div_q   <= 16'd1;
      ph_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          acc_q   <= '0;
          cnt_q   <= '0;
          smp_q   <= '0;
          freq_q  <= freq_word;
          ph_q    <= {phase3, phase2, phase1};
          div_q   <= (div == 16'd0) ? 16'd1 : div;
        end
        RUN: begin
          cnt_q <= cnt_wrap ? '0 : cnt_q + 16'd1;
          if (tick) begin
            acc_q <= acc_q + freq_q;
            smp_q <= smp_q + 1'b1;
            if (smp_q == '1) state_q <= FLUSH;
          end
        end
        FLUSH: if (vld1_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Two-stage sample pipeline: phase index on the tick, table lookup into the output registers next
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld1_q  <= 1'b0;
      valid_q <= 1'b0;
      p_q     <= '0;
      data_q  <= {3{MID}};
    end else begin
      vld1_q  <= tick;
      valid_q <= vld1_q;
      if (tick) p_q <= p_d;
      if (vld1_q) data_q <= data_d;
    end
  end
  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign data1 = data_q[0];
  assign data2 = data_q[1];
  assign data3 = data_q[2];
endmodule

// File: tb/tb_three_phase_dds.sv
// tb_three_phase_dds: scoreboard bench for the three-channel burst sine generator
module tb_three_phase_dds;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] freq_word = '0;
  logic [15:0] phase1 = '0, phase2 = '0, phase3 = '0, div = '0;
  logic        busy, done, valid;
  logic [13:0] data1, data2, data3;
  int          total = 0;
  int          bad = 0;
  logic [41:0] sb[$];

  three_phase_dds dut (
    .clk(clk), .reset(reset), .start(start), .freq_word(freq_word),
    .phase1(phase1), .phase2(phase2), .phase3(phase3), .div(div),
    .busy(busy), .done(done), .valid(valid),
    .data1(data1), .data2(data2), .data3(data3)
  );

  always #10 clk = ~clk;

  function automatic logic [13:0] model(input logic [11:0] p);
    real v;
    v = 8191.0 * $sin(2.0 * 3.14159265358979323846 * real'(p) / 4096.0);
    return 14'(8192 + ((v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5)));
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra got valid with empty scoreboard data=%0d/%0d/%0d", data1, data2, data3);
      end else begin
        logic [41:0] e;
        e = sb.pop_front();
        if ({data1, data2, data3} !== e)
          begin bad++; $display("FAIL sb_sample got=%0d/%0d/%0d want=%0d/%0d/%0d", data1, data2, data3, e[41:28], e[27:14], e[13:0]); end
      end
    end
  end

  task automatic launch(input logic [31:0] fw, input logic [15:0] a, b, c, dv);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 2048; i++) begin
      sb.push_back({model(12'((acc + {a, 16'h0}) >> 20)), model(12'((acc + {b, 16'h0}) >> 20)),
                    model(12'((acc + {c, 16'h0}) >> 20))});
      acc = acc + fw;
    end
    freq_word = fw; phase1 = a; phase2 = b; phase3 = c; div = dv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic observe(input int budget, input int tail, output int first, output int dcyc,
                         output int nv, output int nd, output logic bd, output logic [41:0] ld);
    first = -1; dcyc = -1; nv = 0; nd = 0; bd = 1'bx; ld = 'x;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      if (valid) begin nv++; ld = {data1, data2, data3}; if (first < 0) first = c; end
      if (done) begin nd++; if (dcyc < 0) begin dcyc = c; bd = busy; end end
      if (dcyc >= 0 && c >= dcyc + tail) break;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if ({busy, valid, done} !== 3'b000) begin bad++; $display("FAIL rst_ctrl got=%b want=000", {busy, valid, done}); end
    total++; if ({data1, data2, data3} !== {3{14'd8192}}) begin bad++; $display("FAIL rst_data got=%0d/%0d/%0d want=8192", data1, data2, data3); end
    reset = 1'b0;
    @(negedge clk);
    total++; if ({busy, valid, done} !== 3'b000) begin bad++; $display("FAIL rel_ctrl got=%b want=000", {busy, valid, done}); end
    total++; if ({data1, data2, data3} !== {3{14'd8192}}) begin bad++; $display("FAIL rel_data got=%0d/%0d/%0d want=8192", data1, data2, data3); end
  endtask

  task automatic test_quadrature;
    int f, d, nv, nd; logic bd; logic [41:0] ld;
    launch(32'h4000_0000, 16'h0, 16'h0, 16'h0, 16'd1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL quad_busy got=%b want=1", busy); end
    observe(2100, 3, f, d, nv, nd, bd, ld);
    total++; if (f != 3) begin bad++; $display("FAIL quad_first got=%0d want=3", f); end
    total++; if (d != 2050) begin bad++; $display("FAIL quad_done_cyc got=%0d want=2050", d); end
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL quad_busy_at_done got=%b want=0", bd); end
    total++; if (nv != 2048 || nd != 1) begin bad++; $display("FAIL quad_counts got=%0d/%0d want=2048/1", nv, nd); end
    total++; if (ld[41:28] !== 14'd1) begin bad++; $display("FAIL quad_last got=%0d want=1", ld[41:28]); end
  endtask

  task automatic test_constant;
    int f, d, nv, nd; logic bd; logic [41:0] ld;
    launch(32'h0, 16'h0000, 16'h4000, 16'hC000, 16'd1);
    observe(2100, 3, f, d, nv, nd, bd, ld);
    total++; if (ld !== {14'd8192, 14'd16383, 14'd1}) begin bad++; $display("FAIL const_data got=%0d/%0d/%0d want=8192/16383/1", ld[41:28], ld[27:14], ld[13:0]); end
    total++; if (nv != 2048 || d != 2050) begin bad++; $display("FAIL const_timing got=%0d/%0d want=2048/2050", nv, d); end
  endtask

  task automatic test_div;
    int f, d, nv, nd; logic bd; logic [41:0] ld;
    launch(32'h0123_4567, 16'($urandom), 16'($urandom), 16'($urandom), 16'd4);
    observe(8300, 3, f, d, nv, nd, bd, ld);
    total++; if (f != 3 || d != 8191) begin bad++; $display("FAIL div4_timing got=%0d/%0d want=3/8191", f, d); end
    total++; if (nv != 2048 || nd != 1) begin bad++; $display("FAIL div4_counts got=%0d/%0d want=2048/1", nv, nd); end
    launch(32'h0765_4321, 16'($urandom), 16'($urandom), 16'($urandom), 16'd0);
    observe(2100, 3, f, d, nv, nd, bd, ld);
    total++; if (f != 3 || d != 2050) begin bad++; $display("FAIL div0_timing got=%0d/%0d want=3/2050", f, d); end
    total++; if (nv != 2048 || nd != 1) begin bad++; $display("FAIL div0_counts got=%0d/%0d want=2048/1", nv, nd); end
  endtask

  task automatic test_back_to_back;
    int f, d, nv, nd; logic bd; logic [41:0] ld;
    launch(32'h0222_2222, 16'h1234, 16'h5678, 16'h9ABC, 16'd2);
    fork
      observe(4200, 1, f, d, nv, nd, bd, ld);
      for (int i = 0; i < 200; i++) begin
        start = 1'($urandom); freq_word = $urandom; div = 16'($urandom_range(0, 3)); phase1 = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
    join
    total++; if (d != 4097) begin bad++; $display("FAIL b2b_done_cyc got=%0d want=4097", d); end
    total++; if (nv != 2048 || nd != 1) begin bad++; $display("FAIL b2b_counts got=%0d/%0d want=2048/1", nv, nd); end
    launch(32'h0333_3333, 16'h0, 16'h8000, 16'h2000, 16'd1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b want=1", busy); end
    observe(2100, 3, f, d, nv, nd, bd, ld);
    total++; if (d != 2050 || nv != 2048) begin bad++; $display("FAIL b2b_second got=%0d/%0d want=2050/2048", d, nv); end
  endtask

  task automatic test_wrap;
    int f, d, nv, nd; logic bd; logic [41:0] ld;
    launch(32'hC000_0000, 16'h0, 16'h0, 16'h0, 16'd1);
    observe(2100, 3, f, d, nv, nd, bd, ld);
    total++; if (ld[41:28] !== 14'd16383) begin bad++; $display("FAIL wrap_last got=%0d want=16383", ld[41:28]); end
    total++; if (nv != 2048 || nd != 1) begin bad++; $display("FAIL wrap_counts got=%0d/%0d want=2048/1", nv, nd); end
  endtask

  task automatic test_reset_mid;
    int f, d, nv, nd; logic bd; logic [41:0] ld;
    launch(32'h1234_5678, 16'h0100, 16'h0200, 16'h0300, 16'd1);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    sb.delete();
    total++; if ({busy, valid, done} !== 3'b000) begin bad++; $display("FAIL mid_rst_ctrl got=%b want=000", {busy, valid, done}); end
    total++; if ({data1, data2, data3} !== {3{14'd8192}}) begin bad++; $display("FAIL mid_rst_data got=%0d/%0d/%0d want=8192", data1, data2, data3); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    observe(3000, 0, f, d, nv, nd, bd, ld);
    total++; if (nv != 0 || nd != 0) begin bad++; $display("FAIL mid_rst_after got=%0d/%0d want=0/0", nv, nd); end
  endtask

  initial begin
    test_reset();
    test_quadrature();
    test_constant();
    test_div();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/three_phase_dds.md
Name: three_phase_dds

Overview:
- Burst test-signal generator that produces the three antenna sample streams consumed by the phase-extraction chain.
- Synthesises one common-frequency sine per channel, each with an independent programmable phase offset.
- Each burst is exactly one FFT frame (2^FFT_DEPTH samples) at a programmable sample rate.
- Used as the on-chip loopback source for bench and hardware self-test of phase extraction.

Parameters:
- DATA_WIDTH, 14: bits per output sample, offset binary.
- FFT_DEPTH, 11: log2 of samples per burst (2048).
- LUT_ADDR, 10: log2 of quarter-wave table entries; the phase index is LUT_ADDR+2 bits.
- ACC_WIDTH, 32: phase accumulator and tuning-word width; must be at least 16 and at least LUT_ADDR+2.

Ports:
- clk, input, 1: system clock, 50.0MHz.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a burst; sampled only when busy=0.
- freq_word, input, ACC_WIDTH: phase increment per sample.
- phase1, input, 16: channel 1 phase offset; full circle is 2^16.
- phase2, input, 16: channel 2 phase offset.
- phase3, input, 16: channel 3 phase offset.
- div, input, 16: clk cycles per sample; 0 is treated as 1.
- busy, output, 1: burst in progress.
- done, output, 1: one-cycle pulse at the end of a burst.
- valid, output, 1: one-cycle pulse when data1..3 present a new sample.
- data1, output, DATA_WIDTH: antenna #1 sample.
- data2, output, DATA_WIDTH: antenna #2 sample.
- data3, output, DATA_WIDTH: antenna #3 sample.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - busy=0, done=0, valid=0.
  - data1..3 = 2^(DATA_WIDTH-1) (8192 for the default width).
  - Accumulator, tick counter and sample counter cleared; FSM goes to IDLE.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - start=1 latches freq_word, phase1..3 and div (0 becomes 1), clears acc, tick counter and sample counter.
  - Next cycle: state is RUN and busy=1.
  - Port changes after the latch have no effect until the next burst.
- RUN:
  - A sample tick occurs on the first RUN cycle and then every div cycles.
  - On each tick, for each channel k: p_k = (acc + (phase_k << (ACC_WIDTH-16))) mod 2^ACC_WIDTH, truncated to its top LUT_ADDR+2 bits.
  - On each tick, acc <= (acc + freq_word) mod 2^ACC_WIDTH; wrap-around is silent.
  - After tick number 2^FFT_DEPTH, go to FLUSH.
- Sample value and latency:
  - out_k = 2^(DATA_WIDTH-1) + round((2^(DATA_WIDTH-1)-1) * sin(2*pi*p_k / 2^(LUT_ADDR+2))), rounding half away from zero.
  - Output must be bit-exact to this formula. A quarter-wave table with mirroring and negation is mandatory; it must return exact peaks at p=2^LUT_ADDR (16383) and p=3*2^LUT_ADDR (1).
  - Latency is 2 clk cycles: a tick at cycle t gives data1..3 and valid=1 at cycle t+2. All three channels update together.
  - data holds between valid pulses and after the burst ends.
  - valid pulses exactly 2^FFT_DEPTH times per burst.
- FLUSH:
  - Waits for the last sample to leave the pipeline.
  - On the cycle of the final valid: done=1, busy=0, state returns to IDLE.
  - start is accepted on the cycle after done.
- Boundary conditions:
  - start while busy=1 is ignored, with no effect on the counters.
  - freq_word=0 gives a constant output per channel.
  - div=1 gives valid on every cycle.
  - reset mid-burst aborts the burst: no done pulse, and no further valid pulses.

Test Plan:
1. Assert reset, then deassert -> data1..3=8192, busy=0, valid=0, done=0. Assert reset mid-burst -> same values immediately; valid stays 0 afterwards.
2. freq_word=0x40000000, div=1, phase1..3=0, start pulse at cycle 0:
   - busy=1 from cycle 1; first valid at cycle 3.
   - data1 sequence is 8192, 16383, 8192, 1, repeating.
   - Exactly 2048 valids; done=1 with the last valid at cycle 2050; busy=0 that cycle.
3. freq_word=0, phase1=0x0000, phase2=0x4000, phase3=0xC000 -> every sample is data1=8192, data2=16383, data3=1.
4. div=4 -> valid every 4th cycle, 2048 pulses over 8192 cycles. div=0 -> identical timing to div=1.
5. start pulsed repeatedly during a burst -> the burst still yields exactly 2048 valids and one done. start on the cycle after done -> a new burst, busy=1 on the next cycle.
6. freq_word=0xC0000000 (wrap-around) -> data1 sequence is 8192, 1, 8192, 16383, repeating; the accumulator wraps with no glitch.
